// File: rtl/load_pkg.sv
// -----------------------------------------------------------------------------
// load_pkg
// Shared definitions for the RV32I multi-cycle load path:
//   - funct3 encodings of the five legal load instructions
//   - FSM state encoding used by load_handler
//   - is_legal() : funct3 names a load this unit supports
//   - is_split() : access straddles a word boundary and needs a second read
// -----------------------------------------------------------------------------
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ0 = 2'd1;  // reading the low word
   localparam logic [1:0] ST_REQ1 = 2'd2;  // reading the high word (split only)
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic is_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Words split at any non-zero offset, halfwords only when they start in
   // the last byte lane; bytes always fit in one word.
   function automatic logic is_split(input logic [2:0] f3, input logic [1:0] offset);
      logic split;
      split = 1'b0;
      if (f3 == F3_LW)
         split = (offset != 2'd0);
      else if ((f3 == F3_LH) || (f3 == F3_LHU))
         split = (offset == 2'd3);
      return split;
   endfunction

endpackage

// File: rtl/load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational byte/halfword/word extraction with sign or zero extension.
// Little-endian: the addressed byte is byte <offset> of the 64-bit {hi,lo}.
// Ports:
//   data    in  64  {hi word, lo word}; hi is zero for non-split accesses
//   offset  in   2  byte offset of the load address within the low word
//   funct3  in   3  load type (LB/LH/LW/LBU/LHU); other codes give 0
//   result  out 32  extended load result
// -----------------------------------------------------------------------------
module load_extender
   import load_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] word;

   // Shift the addressed byte down to lane 0; only the low word is kept.
   assign word = 32'(data >> {offset, 3'b000});

   always_comb begin
      // NOTE: every path of a combinational block must assign its outputs;
      // the default here is what keeps an unlisted funct3 from inferring a latch.
      result = 32'd0;
      case (funct3)
         F3_LB:   result = {{24{word[7]}}, word[7:0]};
         F3_LBU:  result = {24'd0, word[7:0]};
         F3_LH:   result = {{16{word[15]}}, word[15:0]};
         F3_LHU:  result = {16'd0, word[15:0]};
         F3_LW:   result = word;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_handler.sv
// -----------------------------------------------------------------------------
// load_handler
// Multi-cycle RV32I load unit. Accepts a load request, reads one or two
// aligned words over a req/ack handshake, extracts and extends the result
// and returns it with a one-cycle done pulse. busy stalls the pipeline.
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  load request, only sampled while idle
//   funct3     in   3  load type
//   addr       in  32  byte address of the load
//   busy       out  1  high from the cycle after acceptance through done
//   done       out  1  one-cycle pulse, rdata/fault valid
//   rdata      out 32  extended result, held until the next done
//   fault      out  1  illegal funct3, valid with done
//   mem_req    out  1  memory read request
//   mem_addr   out 32  word-aligned read address
//   mem_ack    in   1  memory read complete
//   mem_rdata  in  32  read data, valid with mem_ack
// -----------------------------------------------------------------------------
module load_handler
   import load_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   logic [1:0]  state;
   logic [2:0]  f3_q;
   logic [1:0]  offset_q;
   logic [31:0] lo_q;
   logic [63:0] ext_data;
   logic [31:0] ext_result;

   assign busy = (state != ST_IDLE);

   // The extender sees the word arriving this cycle, so the result can be
   // registered on the final ack without an extra cycle.
   always_comb begin
      ext_data = {32'd0, lo_q};
      if (state == ST_REQ0)
         ext_data = {32'd0, mem_rdata};
      else if (state == ST_REQ1)
         ext_data = {mem_rdata, lo_q};
   end

   load_extender u_extender (
      .data   (ext_data),
      .offset (offset_q),
      .funct3 (f3_q),
      .result (ext_result)
   );

   // Control and visible outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= ST_IDLE;
         done     <= 1'b0;
         fault    <= 1'b0;
         rdata    <= 32'd0;
         mem_req  <= 1'b0;
         mem_addr <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (is_legal(funct3)) begin
                     state    <= ST_REQ0;
                     mem_req  <= 1'b1;
                     mem_addr <= {addr[31:2], 2'b00};
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     fault <= 1'b1;
                     rdata <= 32'd0;
                  end
               end
            end
            ST_REQ0: begin
               if (mem_ack) begin
                  if (is_split(f3_q, offset_q)) begin
                     state    <= ST_REQ1;
                     mem_addr <= mem_addr + 32'd4;  // wraps at 2^32
                  end else begin
                     state   <= ST_DONE;
                     mem_req <= 1'b0;
                     done    <= 1'b1;
                     fault   <= 1'b0;
                     rdata   <= ext_result;
                  end
               end
            end
            ST_REQ1: begin
               if (mem_ack) begin
                  state   <= ST_DONE;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  fault   <= 1'b0;
                  rdata   <= ext_result;
               end
            end
            default: state <= ST_IDLE;  // ST_DONE: single-cycle result slot
         endcase
      end
   end

   // Request context and low word.
   // NOTE: these are deliberately left out of reset: each is written by an
   // accepted request before anything reads it, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && start) begin
         f3_q     <= funct3;
         offset_q <= addr[1:0];
      end
      if ((state == ST_REQ0) && mem_ack)
         lo_q <= mem_rdata;
   end

endmodule
